// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer and flush.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 32'd96,
  parameter int unsigned       CTRL_W      = 32'd8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int unsigned       CNT_W       = 32'd16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              ready_q, ready_d;
  logic [CTRL_W-1:0] ctrl_out_q, ctrl_out_d;
  logic              in_xfer_s;
  logic              out_xfer_s;

  assign in_xfer_s  = valid_i & ready_q;
  assign out_xfer_s = m_valid_q & ready_i;

  // Next-state for main/skid entries; the skid only fills while M is held by a stall.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_xfer_s) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_xfer_s) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = ctrl_i;
        m_data_d  = data_i;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_xfer_s) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = ctrl_i;
      s_data_d  = data_i;
    end else begin
      s_valid_d = s_valid_q;
    end
    ready_d    = ~s_valid_d;
    ctrl_out_d = m_valid_d ? m_ctrl_d : CTRL_BUBBLE;
  end

  // Stage storage and registered handshake/outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q  <= 1'b0;
      m_ctrl_q   <= {CTRL_W{1'b0}};
      m_data_q   <= {DATA_W{1'b0}};
      s_valid_q  <= 1'b0;
      s_ctrl_q   <= {CTRL_W{1'b0}};
      s_data_q   <= {DATA_W{1'b0}};
      ready_q    <= 1'b1;
      ctrl_out_q <= CTRL_BUBBLE;
    end else begin
      m_valid_q  <= m_valid_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      ready_q    <= ready_d;
      ctrl_out_q <= ctrl_out_d;
    end
  end

  assign valid_o = m_valid_q;
  assign ready_o = ready_q;
  assign ctrl_o  = ctrl_out_q;
  assign data_o  = m_data_q;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush does not touch them.
  always_comb begin
    if (m_valid_q && !ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!m_valid_q && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter state, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = {CNT_W{1'b0}};
  assign bubble_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, saturation sequence,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int NMAX = 15;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          rst_i, flush_i, valid_i, ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          ready_o, valid_o;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [NW-1:0] stall_cnt_o, bubble_cnt_o;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .CNT_W(NW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o),
    .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: an ordered queue of at most two entries
  typedef struct { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] m_last;
  int            m_stall, m_bubble;

  typedef struct {
    bit rst, flush, vi, ri;
    logic [CW-1:0] c; logic [DW-1:0] d;
    bit ev, er;
    logic [CW-1:0] ec; logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl[24];

  function automatic vec_t mk(bit rst, bit fl, bit vi, bit ri, logic [CW-1:0] c, logic [DW-1:0] d,
                              bit ev, bit er, logic [CW-1:0] ec, logic [DW-1:0] ed);
    vec_t v;
    v.rst = rst; v.flush = fl; v.vi = vi; v.ri = ri; v.c = c; v.d = d;
    v.ev = ev; v.er = er; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic model_step(input bit rst, input bit fl, input bit vi, input bit ri,
                            input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit in_x, out_x;
    ent_t e;
    if (rst) begin
      mq.delete(); m_last = '0; m_stall = 0; m_bubble = 0;
    end else begin
      if (PERF) begin
        if (mq.size() > 0 && !ri && m_stall < NMAX) m_stall++;
        if (mq.size() == 0 && m_bubble < NMAX) m_bubble++;
      end
      in_x  = vi && (mq.size() < 2);
      out_x = (mq.size() > 0) && ri;
      if (fl) mq.delete();
      else begin
        if (out_x) void'(mq.pop_front());
        if (in_x) begin e.c = c; e.d = d; mq.push_back(e); end
      end
      if (mq.size() > 0) m_last = mq[0].d;
    end
  endtask

  task automatic apply(input bit rst, input bit fl, input bit vi, input bit ri,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    rst_i = rst; flush_i = fl; valid_i = vi; ready_i = ri; ctrl_i = c; data_i = d;
    @(posedge clk);
    model_step(rst, fl, vi, ri, c, d);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, {127'd0, valid_o}, {127'd0, mq.size() > 0});
    chk({tag, ".ready"}, {127'd0, ready_o}, {127'd0, mq.size() < 2});
    chk({tag, ".ctrl"}, {120'd0, ctrl_o}, {120'd0, (mq.size() > 0) ? mq[0].c : 8'h00});
    chk({tag, ".data"}, {32'd0, data_o}, {32'd0, m_last});
    chk({tag, ".stall"}, {124'd0, stall_cnt_o}, 128'(m_stall));
    chk({tag, ".bubble"}, {124'd0, bubble_cnt_o}, 128'(m_bubble));
  endtask

  initial begin
    // rst flush vi ri ctrl data  -> valid ready ctrl data
    tbl[0]  = mk(1,0,0,1, 8'h00, 96'h0,  0,1, 8'h00, 96'h0);
    tbl[1]  = mk(0,0,1,1, 8'hA5, 96'h1,  1,1, 8'hA5, 96'h1);
    tbl[2]  = mk(0,0,1,1, 8'hA5, 96'h2,  1,1, 8'hA5, 96'h2);
    tbl[3]  = mk(0,0,1,1, 8'hA5, 96'h3,  1,1, 8'hA5, 96'h3);
    tbl[4]  = mk(0,0,1,1, 8'hA5, 96'h4,  1,1, 8'hA5, 96'h4);
    tbl[5]  = mk(0,0,0,1, 8'h00, 96'h0,  0,1, 8'h00, 96'h4);
    tbl[6]  = mk(0,0,1,0, 8'hA5, 96'h10, 1,1, 8'hA5, 96'h10);
    tbl[7]  = mk(0,0,1,0, 8'hA5, 96'h11, 1,0, 8'hA5, 96'h10);
    tbl[8]  = mk(0,0,1,0, 8'hA5, 96'h12, 1,0, 8'hA5, 96'h10);
    tbl[9]  = mk(0,0,1,1, 8'hA5, 96'h12, 1,1, 8'hA5, 96'h11);
    tbl[10] = mk(0,0,1,1, 8'hA5, 96'h12, 1,1, 8'hA5, 96'h12);
    tbl[11] = mk(0,0,0,1, 8'h00, 96'h0,  0,1, 8'h00, 96'h12);
    tbl[12] = mk(0,0,1,0, 8'h5A, 96'h30, 1,1, 8'h5A, 96'h30);
    tbl[13] = mk(0,0,1,0, 8'h5A, 96'h31, 1,0, 8'h5A, 96'h30);
    tbl[14] = mk(0,1,0,0, 8'h00, 96'h0,  0,1, 8'h00, 96'h30);
    tbl[15] = mk(0,0,0,1, 8'h00, 96'h0,  0,1, 8'h00, 96'h30);
    tbl[16] = mk(0,1,1,1, 8'hA5, 96'h20, 0,1, 8'h00, 96'h30);
    tbl[17] = mk(0,0,0,1, 8'h00, 96'h0,  0,1, 8'h00, 96'h30);
    tbl[18] = mk(0,0,1,1, 8'hA5, 96'h40, 1,1, 8'hA5, 96'h40);
    tbl[19] = mk(0,1,0,1, 8'h00, 96'h0,  0,1, 8'h00, 96'h40);
    tbl[20] = mk(0,0,1,0, 8'hA5, 96'h50, 1,1, 8'hA5, 96'h50);
    tbl[21] = mk(0,0,1,0, 8'hA5, 96'h51, 1,0, 8'hA5, 96'h50);
    tbl[22] = mk(1,0,1,0, 8'hA5, 96'h52, 0,1, 8'h00, 96'h0);
    tbl[23] = mk(0,0,0,0, 8'h00, 96'h0,  0,1, 8'h00, 96'h0);

    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; ctrl_i = '0; data_i = '0;
    m_last = '0; m_stall = 0; m_bubble = 0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].rst, tbl[i].flush, tbl[i].vi, tbl[i].ri, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d.valid", i), {127'd0, valid_o}, {127'd0, tbl[i].ev});
      chk($sformatf("vec%0d.ready", i), {127'd0, ready_o}, {127'd0, tbl[i].er});
      chk($sformatf("vec%0d.ctrl", i), {120'd0, ctrl_o}, {120'd0, tbl[i].ec});
      chk($sformatf("vec%0d.data", i), {32'd0, data_o}, {32'd0, tbl[i].ed});
      chk($sformatf("vec%0d.stall", i), {124'd0, stall_cnt_o}, 128'(m_stall));
      chk($sformatf("vec%0d.bubble", i), {124'd0, bubble_cnt_o}, 128'(m_bubble));
    end

    // Stall counter saturation, then flush must leave it saturated
    apply(1, 0, 0, 0, 8'h00, 96'h0);
    apply(0, 0, 1, 0, 8'hC3, 96'h77);
    for (int k = 0; k < 20; k++) apply(0, 0, 0, 0, 8'h00, 96'h0);
    chk("sat.stall", {124'd0, stall_cnt_o}, PERF ? 128'd15 : 128'd0);
    chk("sat.bubble", {124'd0, bubble_cnt_o}, PERF ? 128'd1 : 128'd0);
    apply(0, 1, 0, 0, 8'h00, 96'h0);
    chk("sat.stall_after_flush", {124'd0, stall_cnt_o}, PERF ? 128'd15 : 128'd0);
    chk("sat.valid_after_flush", {127'd0, valid_o}, 128'd0);
    chk_model("sat");

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            8'($urandom), {$urandom, $urandom, $urandom});
      chk_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the CPU datapath; the successor to the fixed ID/EX latch.
- Carries a generic control bundle and data bundle between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake so a downstream stall back-pressures upstream.
- Includes a one-entry skid buffer so the registered ready still allows full throughput, plus a synchronous flush that inserts a bubble.

Parameters:
- DATA_W, 96: width of the data bundle (e.g. RS data, RT data, sign-extended immediate).
- CTRL_W, 8: width of the control bundle (RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp[1:0]).
- CTRL_BUBBLE, 0: value driven on ctrl_o whenever the stage holds no valid instruction.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard stage contents and insert a bubble.
- valid_i  in  1  upstream presents an instruction.
- ready_o  out  1  stage can accept; registered.
- ctrl_i  in  CTRL_W  upstream control bundle.
- data_i  in  DATA_W  upstream data bundle.
- valid_o  out  1  stage holds a valid instruction.
- ready_i  in  1  downstream accepts this cycle.
- ctrl_o  out  CTRL_W  control bundle to downstream.
- data_o  out  DATA_W  data bundle to downstream.
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0.
- bubble_cnt_o  out  CNT_W  cycles with valid_o=0.

Behaviour:
- Storage is two entries: main M (drives outputs) and skid S. Each entry holds {valid, ctrl, data}.
- Transfer rules:
  - Input transfer: valid_i && ready_o.
  - Output transfer: valid_o && ready_i.
- Output mapping:
  - valid_o = M.valid.
  - ctrl_o = M.ctrl when M.valid, else CTRL_BUBBLE.
  - data_o = M.data (holds its last value while invalid).
- ready_o = ~S.valid, registered; it never depends combinationally on ready_i.
- Update priority each cycle: rst_i, then flush_i, then normal operation.
- Normal operation:
  - M empty, or output transfer this cycle: if S.valid, M <= S and S.valid <= 0. Otherwise M <= input, valid only if an input transfer occurred.
  - M valid and no output transfer: an input transfer writes S, so S.valid <= 1 and ready_o = 0 next cycle.
- Timing:
  - Latency is 1 cycle, input transfer to valid_o.
  - Sustained throughput is 1 per cycle while ready_i=1.
  - Order is strictly FIFO.
  - No input is dropped except by flush.
- Flush:
  - M.valid <= 0 and S.valid <= 0; any input transfer in the same cycle is discarded.
  - Next cycle: valid_o=0, ctrl_o=CTRL_BUBBLE, ready_o=1.
  - data_o is unchanged by flush.
- Reset: M and S cleared, valid_o=0, ready_o=1, ctrl_o=CTRL_BUBBLE, data_o=0, counters 0. Reset mid-stall drops all held entries.
- Boundaries:
  - Both entries full and ready_i=0: hold everything; ready_o stays 0.
  - Both full and ready_i=1: M <= S, and ready_o returns to 1 the following cycle.
  - flush_i with ready_i=1 in the same cycle: the output transfer still counts as taken downstream, but the stage empties.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle with valid_o && !ready_i.
  - bubble_cnt_o increments each cycle with !valid_o.
  - Both saturate at 2^CNT_W-1, clear only on rst_i, and are unaffected by flush_i.
- Undefined: both ports are present and tied to 0, and no counter logic is built.

Test Plan:
- Reset, then stream 4 inputs (data 0x1..0x4, ctrl 0xA5) with ready_i=1 -> valid_o rises 1 cycle after the first input; outputs 0x1..0x4 on consecutive cycles; ready_o stays 1.
- Push 0x10, 0x11, 0x12 with ready_i=0 -> 0x10 in M, 0x11 in S, ready_o=0 from the cycle after the 0x11 transfer, 0x12 not accepted. Raise ready_i -> 0x10 then 0x11 emitted, ready_o=1 again, then 0x12 accepted.
- Both entries full, assert flush_i for 1 cycle -> next cycle valid_o=0, ctrl_o=CTRL_BUBBLE (0x00), ready_o=1; the flushed values never appear.
- Assert flush_i in the same cycle as input transfer 0x20 -> 0x20 discarded; valid_o=0 next cycle.
- Assert rst_i while stalled with both entries full -> next cycle valid_o=0, ready_o=1, data_o=0, counters=0.
- PIPE_STAGE_PERF_EN defined, CNT_W=4: hold valid_o=1 with ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15; a subsequent flush leaves it at 15.
